// File: rtl/frame_scanout_pkg.sv
// frame_scanout_pkg: shared types and constants for the frame scan-out block.
// Revision: 1.0
`default_nettype none

package frame_scanout_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // A FIFO entry is {data, pix_flags_t}; the data width is a parameter of the top.
  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } pix_flags_t;

endpackage

`default_nettype wire

// File: rtl/frame_scanout_if.sv
// frame_scanout_if: RAM read port plus output pixel stream of the scan-out block.
// Revision: 1.0
`default_nettype none

interface frame_scanout_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 17
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] pix_data;
  logic              pix_sof;
  logic              pix_eol;
  logic              pix_eof;

  modport master (
    output rd_en, rd_addr, pix_valid, pix_data, pix_sof, pix_eol, pix_eof,
    input  rd_data, pix_ready
  );

  modport slave (
    input  rd_en, rd_addr, pix_valid, pix_data, pix_sof, pix_eol, pix_eof,
    output rd_data, pix_ready
  );
endinterface

`default_nettype wire

// File: rtl/frame_scanout_fifo.sv
// scanout_fifo: FIFO_DEPTH-entry synchronous FIFO with count, same-cycle push+pop.
// Revision: 1.0
`default_nettype none

module scanout_fifo
  import frame_scanout_pkg::*;
#(
  parameter int W = 35
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_push,
  input  wire logic [W-1:0]     i_data,
  input  wire logic             i_pop,
  output logic      [W-1:0]     o_data,
  output logic      [CNT_W-1:0] o_count,
  output logic                  o_empty
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [W-1:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop   = i_pop && (r_count != '0);
  assign w_push  = i_push && ((r_count != CNT_W'(FIFO_DEPTH)) || w_pop);
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + PW'(1);
      end
      if (w_pop) r_rd <= r_rd + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/frame_scanout.sv
// frame_scanout: raster read-out of the pixel RAM into a valid/ready stream with frame markers.
// Optional macro FRAME_SCANOUT_CHECKSUM_EN adds a running sum of accepted pixels.
`default_nettype none

module frame_scanout
  import frame_scanout_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 17
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  input  wire logic         start,
  frame_scanout_if.master   bus,
  output logic              busy,
  output logic              frame_done
`ifdef FRAME_SCANOUT_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int EW = DATA_W + $bits(pix_flags_t);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam logic [1:0] S_FIN   = ST_FIN;

  logic [1:0]        r_state;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [ADDR_W-1:0] r_addr;
  logic              r_inflight;
  pix_flags_t        r_iss_flags;

  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_used;
  logic              w_empty;
  logic              w_issue;
  logic              w_pop;
  logic              w_last_x;
  logic              w_last_y;
  pix_flags_t        w_iss_flags;
  logic [EW-1:0]     w_head;
  logic [DATA_W-1:0] w_head_data;
  pix_flags_t        w_head_flags;

  assign w_last_x    = (r_x == XW'(WIDTH - 1));
  assign w_last_y    = (r_y == YW'(HEIGHT - 1));
  assign w_iss_flags = '{sof: (r_x == '0) && (r_y == '0), eol: w_last_x, eof: w_last_x && w_last_y};

  // Credit check: one slot is kept for the read in flight so the FIFO never overflows.
  assign w_used  = w_count + CNT_W'(r_inflight);
  assign w_issue = (r_state == S_RUN) && (w_used <= CNT_W'(FIFO_DEPTH - 2));
  assign w_pop   = !w_empty && bus.pix_ready;

  assign {w_head_data, w_head_flags} = w_head;

  assign bus.rd_en     = w_issue;
  assign bus.rd_addr   = r_addr;
  assign bus.pix_valid = !w_empty;
  assign bus.pix_data  = w_head_data;
  assign bus.pix_sof   = !w_empty && w_head_flags.sof;
  assign bus.pix_eol   = !w_empty && w_head_flags.eol;
  assign bus.pix_eof   = !w_empty && w_head_flags.eof;
  assign busy          = (r_state != S_IDLE);
  assign frame_done    = (r_state == S_FIN);

  scanout_fifo #(.W(EW)) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (r_inflight),
    .i_data  ({bus.rd_data, r_iss_flags}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_addr      <= '0;
      r_inflight  <= 1'b0;
      r_iss_flags <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_iss_flags <= w_iss_flags;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_x     <= '0;
            r_y     <= '0;
            r_addr  <= '0;
          end
        end
        S_RUN: begin
          if (w_issue) begin
            if (w_iss_flags.eof) begin
              r_state <= S_DRAIN;
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
              if (w_last_x) begin
                r_x <= '0;
                if (!w_last_y) r_y <= r_y + YW'(1);
              end else begin
                r_x <= r_x + XW'(1);
              end
            end
          end
        end
        // The eof entry is the last one ever pushed, so its acceptance empties the FIFO.
        S_DRAIN: if (w_pop && w_head_flags.eof) r_state <= S_FIN;
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FRAME_SCANOUT_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        checksum <= '0;
    else if ((r_state == S_IDLE) && start) checksum <= '0;
    else if (w_pop)                      checksum <= checksum + w_head_data;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_frame_scanout.sv
// tb_frame_scanout: randomized self-checking bench for frame_scanout on a 4x2 frame.
`default_nettype none

module tb_frame_scanout;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int DW = 32;
  localparam int AW = 17;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic busy, frame_done;
`ifdef FRAME_SCANOUT_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  frame_scanout_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  frame_scanout #(.WIDTH(W), .HEIGHT(H), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .bus        (bus.master),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef FRAME_SCANOUT_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [N];
  always @(posedge clk)
    if (bus.rd_en) bus.rd_data <= (int'(bus.rd_addr) < N) ? ram[int'(bus.rd_addr)] : 32'hDEAD_BEEF;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] q_data [$];
  logic [2:0]    q_flag [$];
  int            q_cyc  [$];
  int            q_addr [$];
  int            done_cyc [$];
  int            stab_err, reads_early, rd_late, max_out;
  logic [DW-1:0] sum_at_done;

  function automatic logic [2:0] exp_flags(input int i);
    return {i == 0, (i % W) == W - 1, i == N - 1};
  endfunction

  // Drives one frame and records what the sink sees; mode picks the pix_ready pattern.
  task automatic run_frame(input int mode, input int extra_start, input int stop_after);
    int c, ready, done_at, outst;
    logic prev_stall;
    logic [DW-1:0] prev_d;
    logic [2:0] prev_f, fl;
    q_data.delete(); q_flag.delete(); q_cyc.delete(); q_addr.delete(); done_cyc.delete();
    stab_err = 0; reads_early = 0; rd_late = 0; max_out = 0; sum_at_done = '0;
    prev_stall = 1'b0; prev_d = '0; prev_f = '0; done_at = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; c = 1;
    while (c < 400) begin
      fl = {bus.pix_sof, bus.pix_eol, bus.pix_eof};
      if (prev_stall && (!bus.pix_valid || bus.pix_data !== prev_d || fl !== prev_f)) stab_err++;
      if (bus.rd_en) begin
        q_addr.push_back(int'(bus.rd_addr));
        if (c <= 20) reads_early++;
        if (c >= 10 && c <= 20) rd_late++;
      end
      if (frame_done) begin
        done_cyc.push_back(c);
        if (done_at < 0) done_at = c;
`ifdef FRAME_SCANOUT_CHECKSUM_EN
        sum_at_done = checksum;
`endif
      end
      outst = q_addr.size() - q_data.size();
      if (outst > max_out) max_out = outst;
      case (mode)
        1:       ready = c % 2;
        2:       ready = (c > 20) ? 1 : 0;
        3:       ready = ($urandom_range(0, 2) != 0) ? 1 : 0;
        default: ready = 1;
      endcase
      start = (c == extra_start);
      bus.pix_ready = (ready != 0);
      if (bus.pix_valid && ready != 0) begin
        q_data.push_back(bus.pix_data); q_flag.push_back(fl); q_cyc.push_back(c);
      end
      prev_stall = bus.pix_valid && ready == 0;
      prev_d = bus.pix_data; prev_f = fl;
      if (stop_after > 0 && q_data.size() == stop_after) return;
      if (done_at >= 0 && c >= done_at + 3) break;
      @(negedge clk); c++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({bus.rd_en, bus.pix_valid, bus.pix_sof, bus.pix_eol, bus.pix_eof, busy, frame_done} !== 7'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 0000000", {bus.rd_en, bus.pix_valid, bus.pix_sof, bus.pix_eol, bus.pix_eof, busy, frame_done});
    end
    n_cmp++; if (bus.rd_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %0h want 0", bus.rd_addr); end
    n_cmp++; if (bus.pix_data !== '0) begin n_bad++; $display("FAIL reset_data: got %0h want 0", bus.pix_data); end
`ifdef FRAME_SCANOUT_CHECKSUM_EN
    n_cmp++; if (checksum !== '0) begin n_bad++; $display("FAIL reset_checksum: got %0d want 0", checksum); end
`endif
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < N; i++) ram[i] = DW'(i + 100);
    run_frame(0, 0, 0);
    n_cmp++; if (q_data.size() != N) begin n_bad++; $display("FAIL basic_count: got %0d want %0d", q_data.size(), N); end
    for (int i = 0; i < N && i < q_data.size(); i++) begin
      n_cmp++; if (q_data[i] !== DW'(i + 100) || q_flag[i] !== exp_flags(i) || q_cyc[i] != 3 + i) begin
        n_bad++; $display("FAIL basic_pix%0d: got d=%0d f=%b cyc=%0d want d=%0d f=%b cyc=%0d",
                          i, q_data[i], q_flag[i], q_cyc[i], i + 100, exp_flags(i), 3 + i);
      end
    end
    for (int i = 0; i < N && i < q_addr.size(); i++) begin
      n_cmp++; if (q_addr[i] != i) begin n_bad++; $display("FAIL basic_addr%0d: got %0d want %0d", i, q_addr[i], i); end
    end
    n_cmp++; if (done_cyc.size() != 1 || done_cyc[0] != N + 3) begin
      n_bad++; $display("FAIL basic_done: got n=%0d first=%0d want n=1 cyc=%0d", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, N + 3);
    end
`ifdef FRAME_SCANOUT_CHECKSUM_EN
    n_cmp++; if (sum_at_done !== DW'(828)) begin n_bad++; $display("FAIL basic_checksum: got %0d want 828", sum_at_done); end
`endif
  endtask

  task automatic test_toggle_ready();
    run_frame(1, 0, 0);
    n_cmp++; if (q_data.size() != N) begin n_bad++; $display("FAIL toggle_count: got %0d want %0d", q_data.size(), N); end
    for (int i = 0; i < N && i < q_data.size(); i++) begin
      n_cmp++; if (q_data[i] !== ram[i] || q_flag[i] !== exp_flags(i)) begin
        n_bad++; $display("FAIL toggle_pix%0d: got d=%0d f=%b want d=%0d f=%b", i, q_data[i], q_flag[i], ram[i], exp_flags(i));
      end
    end
    n_cmp++; if (stab_err != 0) begin n_bad++; $display("FAIL toggle_stable: got %0d unstable stalls want 0", stab_err); end
    n_cmp++; if (done_cyc.size() != 1 || q_cyc.size() == 0 || done_cyc[0] != q_cyc[q_cyc.size()-1] + 1) begin
      n_bad++; $display("FAIL toggle_done: got n=%0d cyc=%0d want 1 cycle after last accept", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    end
  endtask

  task automatic test_stall();
    run_frame(2, 0, 0);
    n_cmp++; if (reads_early > 4) begin n_bad++; $display("FAIL stall_reads: got %0d reads while stalled want <=4", reads_early); end
    n_cmp++; if (rd_late != 0) begin n_bad++; $display("FAIL stall_rden: got %0d late reads want 0", rd_late); end
    n_cmp++; if (max_out > 4) begin n_bad++; $display("FAIL stall_outstanding: got %0d want <=4", max_out); end
    n_cmp++; if (q_data.size() != N) begin n_bad++; $display("FAIL stall_count: got %0d want %0d", q_data.size(), N); end
    for (int i = 0; i < N && i < q_data.size(); i++) begin
      n_cmp++; if (q_data[i] !== ram[i]) begin n_bad++; $display("FAIL stall_pix%0d: got %0d want %0d", i, q_data[i], ram[i]); end
    end
    n_cmp++; if (stab_err != 0) begin n_bad++; $display("FAIL stall_stable: got %0d want 0", stab_err); end
  endtask

  task automatic test_double_start();
    run_frame(0, 4, 0);
    n_cmp++; if (q_data.size() != N || done_cyc.size() != 1) begin
      n_bad++; $display("FAIL dstart_count: got pix=%0d done=%0d want pix=%0d done=1", q_data.size(), done_cyc.size(), N);
    end
    n_cmp++; if (busy !== 1'b0 || bus.rd_en !== 1'b0) begin
      n_bad++; $display("FAIL dstart_idle: got busy=%b rd_en=%b want 0 0", busy, bus.rd_en);
    end
  endtask

  task automatic test_reset_midframe();
    int spurious = 0;
    run_frame(0, 0, 4);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if ({bus.rd_en, bus.pix_valid, bus.pix_sof, bus.pix_eol, bus.pix_eof, busy, frame_done} !== 7'b0
                 || bus.pix_data !== '0 || bus.rd_addr !== '0) begin
      n_bad++; $display("FAIL midreset_outputs: got ctrl=%b data=%0h addr=%0h want all 0",
                        {bus.rd_en, bus.pix_valid, bus.pix_sof, bus.pix_eol, bus.pix_eof, busy, frame_done}, bus.pix_data, bus.rd_addr);
    end
    repeat (3) begin @(negedge clk); if (frame_done) spurious++; end
    reset_n = 1'b1;
    repeat (2) begin @(negedge clk); if (frame_done) spurious++; end
    n_cmp++; if (spurious != 0) begin n_bad++; $display("FAIL midreset_nodone: got %0d frame_done cycles want 0", spurious); end
    run_frame(0, 0, 0);
    n_cmp++; if (q_data.size() != N || done_cyc.size() != 1 || (done_cyc.size() > 0 && done_cyc[0] != N + 3)) begin
      n_bad++; $display("FAIL midreset_reframe: got pix=%0d done=%0d want pix=%0d done at %0d", q_data.size(), done_cyc.size(), N, N + 3);
    end
    for (int i = 0; i < N && i < q_data.size(); i++) begin
      n_cmp++; if (q_data[i] !== ram[i]) begin n_bad++; $display("FAIL midreset_pix%0d: got %0d want %0d", i, q_data[i], ram[i]); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      logic [DW-1:0] exp_sum = '0;
      for (int i = 0; i < N; i++) begin ram[i] = $urandom(); exp_sum += ram[i]; end
      run_frame(3, 0, 0);
      n_cmp++; if (q_data.size() != N) begin n_bad++; $display("FAIL rand%0d_count: got %0d want %0d", it, q_data.size(), N); end
      for (int i = 0; i < N && i < q_data.size(); i++) begin
        n_cmp++; if (q_data[i] !== ram[i] || q_flag[i] !== exp_flags(i)) begin
          n_bad++; $display("FAIL rand%0d_pix%0d: got d=%0h f=%b want d=%0h f=%b", it, i, q_data[i], q_flag[i], ram[i], exp_flags(i));
        end
      end
      n_cmp++; if (stab_err != 0 || done_cyc.size() != 1 || q_cyc.size() == 0 || done_cyc[0] != q_cyc[q_cyc.size()-1] + 1) begin
        n_bad++; $display("FAIL rand%0d_done: got stab=%0d n_done=%0d want stab=0 one done after last accept", it, stab_err, done_cyc.size());
      end
`ifdef FRAME_SCANOUT_CHECKSUM_EN
      n_cmp++; if (sum_at_done !== exp_sum) begin n_bad++; $display("FAIL rand%0d_checksum: got %0h want %0h", it, sum_at_done, exp_sum); end
`endif
    end
  endtask

  initial begin
    bus.pix_ready = 1'b0;
    for (int i = 0; i < N; i++) ram[i] = '0;
    test_reset();
    test_basic();
    test_toggle_ready();
    test_stall();
    test_double_start();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/frame_scanout.md
# frame_scanout

Downstream stage of the flip/invert image engine. Once the engine reports completion, this block reads the processed frame out of the shared pixel RAM in raster order and presents it as a valid/ready pixel stream with start-of-frame, end-of-line and end-of-frame markers. It hides the RAM read latency behind a small output FIFO, so a continuously-ready sink receives one pixel per clock.

## Interface
- WIDTH, 320, pixels per line
- HEIGHT, 240, lines per frame
- DATA_W, 32, pixel word width (one pixel per RAM word)
- ADDR_W, 17, RAM word address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT
- clk  in  1  single clock; all logic is rising-edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse (the engine's done); begins a frame readout
- rd_en  out  1  RAM read-port enable
- rd_addr  out  ADDR_W  RAM read address = y*WIDTH + x
- rd_data  in  DATA_W  RAM read data, valid exactly one cycle after rd_en
- pix_valid  out  1  stream data valid
- pix_ready  in  1  sink accepts
- pix_data  out  DATA_W  pixel word
- pix_sof  out  1  qualifies pixel (0,0)
- pix_eol  out  1  qualifies x == WIDTH-1
- pix_eof  out  1  qualifies the last pixel of the frame
- busy  out  1  high from the first RUN cycle through the frame_done cycle
- frame_done  out  1  one-cycle pulse after the last pixel is accepted

## Operation
- States: IDLE, RUN, DRAIN, FIN.
- IDLE: start=1 -> RUN; the read address counter clears to 0.
- RUN: issue rd_en when fifo_count + inflight <= 2 (4-deep FIFO, 1 read in flight max). The address increments on each issue. After the issue of address WIDTH*HEIGHT-1 -> DRAIN.
- DRAIN: no reads. When the FIFO is empty, inflight is 0 and the last pixel has been accepted -> FIN.
- FIN: frame_done=1 for one cycle -> IDLE.
- start is ignored outside IDLE.
- rd_data is pushed into the FIFO in the cycle after its rd_en. Each entry carries data plus sof/eol/eof flags, computed from the issuing x/y counters at issue time.
- Handshake: a pixel transfers when pix_valid && pix_ready.
  - pix_valid, pix_data and the flags hold stable while pix_valid && !pix_ready.
  - Push and pop in the same cycle are legal; the count is unchanged.
- x wraps 0..WIDTH-1; y increments on the x wrap and stops at HEIGHT-1.
- Reset (any time, including mid-frame): all outputs 0, FIFO empty, state IDLE. An in-flight read is discarded and no frame_done is produced.

## Timing
- Reset values: rd_en=0, rd_addr=0, pix_valid=0, pix_data=0, pix_sof=pix_eol=pix_eof=0, busy=0, frame_done=0.
- Cycle 0: start sampled. Cycle 1: RUN, rd_en=1, rd_addr=0. Cycle 2: data pushed. Cycle 3: first pix_valid=1, pix_sof=1.
- With pix_ready held at 1: one pixel per cycle. The last pixel is at cycle 2+WIDTH*HEIGHT and frame_done at cycle 3+WIDTH*HEIGHT (76803 for the defaults).
- Backpressure: reads stall within 1 cycle of the FIFO reaching its credit limit. No pixel is dropped or duplicated.

## Configuration
- FRAME_SCANOUT_CHECKSUM_EN defined:
  - Adds output checksum [DATA_W-1:0], reset 0.
  - Cleared when leaving IDLE; adds each accepted pix_data modulo 2^DATA_W.
  - Holds its value from the frame_done cycle until the next start.
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package frame_scanout_pkg: the state enum (IDLE, RUN, DRAIN, FIN), FIFO_DEPTH=4, and the FIFO entry struct {data, sof, eol, eof}.
- Sub-module scanout_fifo: 4-deep synchronous FIFO with push/pop/count, same-cycle push+pop, and async active-low reset.
- Top level holds the FSM, x/y/address counters, inflight flag and optional checksum.

## Test plan
- WIDTH=4, HEIGHT=2, RAM word i = i+100, pix_ready=1, start pulse -> pix_data 100..107 on cycles 3..10; sof on 100; eol on 103 and 107; eof on 107; frame_done at cycle 11.
- Same setup, pix_ready toggling 1/0 every cycle -> identical 8-word sequence, no duplicates, data stable while stalled, frame_done 1 cycle after the final accept.
- pix_ready=0 for 20 cycles after start -> at most 4 reads issued; FIFO full; rd_en low until ready returns; then all 8 pixels delivered in order.
- Second start pulse during RUN -> ignored; exactly 8 pixels and one frame_done.
- reset_n low at pixel 3 -> all outputs 0 asynchronously, no frame_done. A new start then yields a full frame from pixel 100.
- FRAME_SCANOUT_CHECKSUM_EN, data 100..107 -> checksum = 828 at frame_done.
